// File: rtl/dither_bit_packer.sv
`default_nettype none
// ==== dither_bit_packer : raster pixels -> thresholded 1bpp bytes + sof/eol/eof via byte FIFO ====
// ==== Option PACK_CHECKSUM_EN appends an XOR checksum byte (carrying eof) per frame.  rev 1.0  ====
module dither_bit_packer #(
    parameter int IMAGEX     = 64,
    parameter int IMAGEY     = 64,
    parameter int RGB_SIZE   = 8,
    parameter int THRESH     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                pix_valid,
    output logic                pix_ready,
    input  logic [RGB_SIZE-1:0] pix_data,
    output logic                byte_valid,
    input  logic                byte_ready,
    output logic [7:0]          byte_data,
    output logic                byte_sof,
    output logic                byte_eol,
    output logic                byte_eof,
    output logic                frame_done,
    output logic                busy
);
    localparam int COLS = IMAGEX / 8;
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW   = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int NW   = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]       COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0]       ROW_LAST = RW'(IMAGEY - 1);
    localparam logic [NW-1:0]       DEPTH_N  = NW'(FIFO_DEPTH);
    localparam logic [RGB_SIZE-1:0] THR      = RGB_SIZE'(THRESH);

    logic [6:0]    sr_q;
    logic [2:0]    bit_cnt_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [10:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [NW-1:0] cnt_q;
    logic [10:0]   hold_q;
    logic          frame_done_q, busy_q;

    logic          pix_hs, bit_in, data_push, push, pop, sof, eol, last, eof_pop;
    logic [7:0]    byte_d;
    logic [10:0]   push_entry, head;
    logic          not_full;

    assign not_full  = (cnt_q < DEPTH_N);
    assign pix_hs    = pix_valid & pix_ready;
    assign bit_in    = (pix_data >= THR);
    assign byte_d    = {sr_q, bit_in};
    assign data_push = pix_hs && (bit_cnt_q == 3'd7);
    assign sof       = (row_q == '0) && (col_q == '0);
    assign eol       = (col_q == COL_LAST);
    assign last      = eol && (row_q == ROW_LAST);

`ifdef PACK_CHECKSUM_EN
    logic       chk_pend_q, chk_push;
    logic [7:0] xor_q;
    // The checksum byte owns the eof marker, so the last data byte only carries eol.
    assign chk_push   = chk_pend_q && not_full;
    assign pix_ready  = not_full && !chk_pend_q;
    assign push       = data_push | chk_push;
    assign push_entry = chk_push ? {3'b001, xor_q} : {sof, eol, 1'b0, byte_d};
`else
    assign pix_ready  = not_full;
    assign push       = data_push;
    assign push_entry = {sof, eol, last, byte_d};
`endif

    assign head       = mem_q[rd_q];
    assign byte_valid = (cnt_q != '0);
    assign pop        = byte_valid & byte_ready;
    assign eof_pop    = pop & head[8];
    assign {byte_sof, byte_eol, byte_eof, byte_data} = byte_valid ? head : hold_q;
    assign frame_done = frame_done_q;
    assign busy       = busy_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef PACK_CHECKSUM_EN
            chk_pend_q   <= 1'b0;
            xor_q        <= '0;
`endif
        end else if (clear) begin
            sr_q         <= '0;
            bit_cnt_q    <= '0;
            col_q        <= '0;
            row_q        <= '0;
            rd_q         <= '0;
            wr_q         <= '0;
            cnt_q        <= '0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef PACK_CHECKSUM_EN
            chk_pend_q   <= 1'b0;
            xor_q        <= '0;
`endif
        end else begin
            frame_done_q <= eof_pop;
            if (push) begin
                mem_q[wr_q] <= push_entry;
                wr_q        <= wr_q + PW'(1);
            end
            if (pop) begin
                rd_q   <= rd_q + PW'(1);
                hold_q <= head;
            end
            if (push && !pop)      cnt_q <= cnt_q + NW'(1);
            else if (!push && pop) cnt_q <= cnt_q - NW'(1);

            if (pix_hs) begin
                sr_q      <= {sr_q[5:0], bit_in};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (eol) begin
                        col_q <= '0;
                        row_q <= last ? '0 : row_q + RW'(1);
                    end else begin
                        col_q <= col_q + CW'(1);
                    end
                end
            end

            if (pix_hs)       busy_q <= 1'b1;
            else if (eof_pop) busy_q <= 1'b0;
`ifdef PACK_CHECKSUM_EN
            if (data_push) xor_q <= sof ? byte_d : (xor_q ^ byte_d);
            if (data_push && last) chk_pend_q <= 1'b1;
            else if (chk_push)     chk_pend_q <= 1'b0;
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dither_bit_packer.sv
`default_nettype none
// Self-checking bench for dither_bit_packer against a frame-position reference model.
module tb_dither_bit_packer;
    localparam int IMAGEX = 64, IMAGEY = 64, RGB_SIZE = 8, THRESH = 128, FIFO_DEPTH = 4;
    localparam int TOTAL  = IMAGEX * IMAGEY / 8;
    localparam int COLS   = IMAGEX / 8;

    logic clk = 1'b0, rst = 1'b0, clear = 1'b0;
    logic pix_valid = 1'b0, byte_ready = 1'b0;
    logic [RGB_SIZE-1:0] pix_data = '0;
    logic pix_ready, byte_valid, byte_sof, byte_eol, byte_eof, frame_done, busy;
    logic [7:0] byte_data;

    dither_bit_packer #(.IMAGEX(IMAGEX), .IMAGEY(IMAGEY), .RGB_SIZE(RGB_SIZE),
                        .THRESH(THRESH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst(rst), .clear(clear), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_sof(byte_sof), .byte_eol(byte_eol), .byte_eof(byte_eof),
        .frame_done(frame_done), .busy(busy));

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    logic [7:0]  src_q[$];
    logic [10:0] exp_q[$], rx_q[$];
    int m_pix = 0, acc_cnt = 0, fd_cnt = 0;
    logic [7:0] m_sr = '0, m_xor = '0;

    task automatic model_reset();
        m_pix = 0; m_sr = '0; m_xor = '0; acc_cnt = 0; fd_cnt = 0;
        exp_q.delete(); rx_q.delete(); src_q.delete();
    endtask

    // Expected bytes derived from the pixel's position within the frame.
    task automatic model_feed(input logic [7:0] px);
        int b, col, row;
        logic s, e, l;
        m_sr = {m_sr[6:0], (px >= THRESH)};
        m_pix++;
        acc_cnt++;
        if (m_pix % 8 == 0) begin
            b = m_pix / 8 - 1; col = b % COLS; row = b / COLS;
            s = (b == 0); e = (col == COLS - 1); l = (b == TOTAL - 1);
            m_xor = s ? m_sr : (m_xor ^ m_sr);
`ifdef PACK_CHECKSUM_EN
            exp_q.push_back({s, e, 1'b0, m_sr});
            if (l) exp_q.push_back({3'b001, m_xor});
`else
            exp_q.push_back({s, e, l, m_sr});
`endif
            if (l) m_pix = 0;
        end
    endtask

    task automatic cycle(input bit pv, input bit br);
        @(negedge clk);
        pix_valid  = pv && (src_q.size() > 0);
        pix_data   = (src_q.size() > 0) ? src_q[0] : 8'h00;
        byte_ready = br;
        #1;
        if (byte_valid && byte_ready) rx_q.push_back({byte_sof, byte_eol, byte_eof, byte_data});
        if (frame_done) fd_cnt++;
        if (pix_valid && pix_ready) model_feed(src_q.pop_front());
    endtask

    task automatic run_stream(input int pv_pct, input int br_pct, input int max_cyc, output bit tmo);
        int c = 0;
        while ((src_q.size() > 0 || rx_q.size() < exp_q.size()) && c < max_cyc) begin
            cycle($urandom_range(99) < pv_pct, $urandom_range(99) < br_pct);
            c++;
        end
        tmo = (c >= max_cyc);
        cycle(0, 1); cycle(0, 1);
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; pix_valid = 1'b0; byte_ready = 1'b0;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL reset_byte_valid got=%b exp=0", byte_valid); end
        n_tests++; if (pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        n_tests++; if ({byte_sof, byte_eol, byte_eof, byte_data} !== 11'h000) begin
            n_fail++; $display("FAIL reset_head got=%h exp=000", {byte_sof, byte_eol, byte_eof, byte_data}); end
    endtask

    task automatic test_pattern();
        logic [7:0] pat [8];
        pat = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h80};
        do_clear();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            pix_valid = 1'b1; pix_data = pat[i]; byte_ready = 1'b1;
            #1;
            if (i == 7) begin
                n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL pattern_early got=%b exp=0", byte_valid); end
            end
        end
        @(negedge clk);
        pix_valid = 1'b0;
        #1;
        n_tests++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL pattern_valid got=%b exp=1", byte_valid); end
        n_tests++; if ({byte_sof, byte_eol, byte_eof, byte_data} !== {3'b100, 8'hA3}) begin
            n_fail++; $display("FAIL pattern_byte got=%h exp=%h", {byte_sof, byte_eol, byte_eof, byte_data}, {3'b100, 8'hA3}); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pattern_busy got=%b exp=1", busy); end
    endtask

    task automatic test_full_frame();
        bit tmo;
        int neol = 0, neof = 0;
        do_clear();
        for (int i = 0; i < IMAGEX * IMAGEY; i++) src_q.push_back((i % 2 == 0) ? 8'hFF : 8'h00);
        run_stream(100, 100, 20000, tmo);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL full_timeout got=%0d exp=%0d bytes", rx_q.size(), exp_q.size()); end
        n_tests++; if (rx_q.size() != exp_q.size()) begin n_fail++; $display("FAIL full_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL full_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
            if (rx_q[i][9]) neol++;
            if (rx_q[i][8]) neof++;
        end
        n_tests++; if (rx_q.size() < TOTAL || rx_q[TOTAL-1][7:0] !== 8'hAA) begin
            n_fail++; $display("FAIL full_last_data got_size=%0d exp=AA", rx_q.size()); end
        n_tests++; if (neol != IMAGEY || neof != 1) begin n_fail++; $display("FAIL full_markers got eol=%0d eof=%0d exp eol=%0d eof=1", neol, neof, IMAGEY); end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL full_frame_done got=%0d exp=1", fd_cnt); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy got=%b exp=0", busy); end
    endtask

    task automatic test_random();
        bit tmo;
        do_clear();
        for (int i = 0; i < IMAGEX * IMAGEY + 800; i++)
            src_q.push_back(($urandom_range(3) == 0) ? 8'(THRESH - 1 + $urandom_range(1)) : 8'($urandom));
        run_stream(70, 60, 40000, tmo);
        n_tests++; if (tmo || rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL random_count got=%0d exp=%0d", rx_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL random_frame_done got=%0d exp=1", fd_cnt); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL random_busy got=%b exp=1", busy); end
    endtask

    task automatic test_back_to_back();
        bit tmo;
        do_clear();
        for (int i = 0; i < 40; i++) src_q.push_back(8'($urandom));
        repeat (45) cycle(1, 0);
        n_tests++; if (acc_cnt != 32) begin n_fail++; $display("FAIL bp_accepted got=%0d exp=32", acc_cnt); end
        n_tests++; if (pix_ready !== 1'b0) begin n_fail++; $display("FAIL bp_pix_ready got=%b exp=0", pix_ready); end
        n_tests++; if (byte_valid !== 1'b1) begin n_fail++; $display("FAIL bp_byte_valid got=%b exp=1", byte_valid); end
        run_stream(100, 100, 300, tmo);
        n_tests++; if (tmo || acc_cnt != 40 || rx_q.size() != 5) begin
            n_fail++; $display("FAIL bp_drain got acc=%0d bytes=%0d exp acc=40 bytes=5", acc_cnt, rx_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_tests++; if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_byte[%0d] got=%h exp=%h", i, rx_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_clear();
        bit tmo;
        do_clear();
        for (int i = 0; i < 5; i++) src_q.push_back(8'($urandom));
        run_stream(100, 100, 50, tmo);
        do_clear();
        #1;
        n_tests++; if (busy !== 1'b0 || byte_valid !== 1'b0) begin
            n_fail++; $display("FAIL clear_state got busy=%b valid=%b exp 0 0", busy, byte_valid); end
        for (int i = 0; i < 8; i++) src_q.push_back(8'($urandom));
        run_stream(100, 100, 50, tmo);
        n_tests++; if (tmo || rx_q.size() != 1) begin n_fail++; $display("FAIL clear_count got=%0d exp=1", rx_q.size()); end
        else begin
            n_tests++; if (rx_q[0] !== exp_q[0] || rx_q[0][10] !== 1'b1) begin
                n_fail++; $display("FAIL clear_sof_byte got=%h exp=%h", rx_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_clear();
        for (int i = 0; i < 24; i++) src_q.push_back(8'($urandom));
        repeat (30) cycle(1, 0);
        n_tests++; if (acc_cnt != 24 || byte_valid !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_setup got acc=%0d valid=%b exp 24 1", acc_cnt, byte_valid); end
        #2 rst = 1'b0;
        #1;
        n_tests++; if (byte_valid !== 1'b0 || pix_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_async got valid=%b ready=%b busy=%b exp 0 1 0", byte_valid, pix_ready, busy); end
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        cycle(0, 1);
        n_tests++; if (byte_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_after got=%b exp=0", byte_valid); end
    endtask

`ifdef PACK_CHECKSUM_EN
    task automatic test_checksum();
        bit tmo;
        logic [7:0] pat [8];
        pat = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'hFF, 8'h00};
        do_clear();
        for (int i = 0; i < (TOTAL - 1) * 8; i++) src_q.push_back(8'h00);
        for (int i = 0; i < 8; i++) src_q.push_back(pat[i]);
        run_stream(100, 100, 20000, tmo);
        n_tests++; if (tmo || rx_q.size() != TOTAL + 1) begin
            n_fail++; $display("FAIL chk_count got=%0d exp=%0d", rx_q.size(), TOTAL + 1); end
        else begin
            n_tests++; if (rx_q[TOTAL] !== {3'b001, 8'h5A}) begin
                n_fail++; $display("FAIL chk_byte got=%h exp=%h", rx_q[TOTAL], {3'b001, 8'h5A}); end
            n_tests++; if (rx_q[TOTAL-1] !== {3'b010, 8'h5A}) begin
                n_fail++; $display("FAIL chk_last_data got=%h exp=%h", rx_q[TOTAL-1], {3'b010, 8'h5A}); end
        end
        n_tests++; if (fd_cnt != 1) begin n_fail++; $display("FAIL chk_frame_done got=%0d exp=1", fd_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_pattern();
        test_full_frame();
        test_random();
        test_back_to_back();
        test_clear();
        test_reset_mid();
`ifdef PACK_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
